// File: rtl/ext_bus_pkg.sv
// Shared definitions for the EXT_BUS command arbiter: bus bit positions,
// FSM states, well-known command codes and saturating-counter helpers.
package ext_bus_pkg;

    localparam int BUS_W        = 36;
    localparam int BUS_DOUT_LSB = 0;
    localparam int BUS_DIN_LSB  = 16;
    localparam int BUS_DOUT_EN  = 32;
    localparam int BUS_STROBE   = 33;
    localparam int BUS_ENABLE   = 34;

    localparam logic [7:0] CMD_KBD_LO  = 8'h04;
    localparam logic [7:0] CMD_KBD_HI  = 8'h05;
    localparam logic [7:0] CMD_IDE_LO  = 8'h61;
    localparam logic [7:0] CMD_IDE_MID = 8'h62;
    localparam logic [7:0] CMD_IDE_HI  = 8'h63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_ROUTE = 2'd2,
        ST_DROP  = 2'd3
    } arb_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ext_cmd_decode.sv
// Combinational command-range match; the lowest-index matching client wins.
module ext_cmd_decode
    import ext_bus_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter logic [8*NCLIENT-1:0] CMD_LO = '0,
    parameter logic [8*NCLIENT-1:0] CMD_HI = '0
) (
    input  logic [7:0]         cmd,
    output logic [NCLIENT-1:0] sel,
    output logic               hit
);

    // A range with LO > HI can never satisfy both bounds, so it is disabled.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NCLIENT; i++) begin
            if (!hit && (cmd >= CMD_LO[8*i +: 8]) && (cmd <= CMD_HI[8*i +: 8])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end else begin
                sel[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Decodes the command word of each EXT_BUS transaction, routes the following
// strobed words to one handler and muxes that handler's reply onto the bus.
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int NCLIENT = 4,
    // Byte i (bits 8*i+7:8*i) belongs to client i: keyboard on 0, IDE on 1.
    parameter logic [8*NCLIENT-1:0] CMD_LO = {8'h00, 8'h00, CMD_IDE_LO, CMD_KBD_LO},
    parameter logic [8*NCLIENT-1:0] CMD_HI = {8'h00, 8'h00, CMD_IDE_HI, CMD_KBD_HI}
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    inout  wire  [BUS_W-1:0]       EXT_BUS,
    output logic [7:0]             cl_cmd,
    output logic [3:0]             cl_cnt,
    output logic [15:0]            cl_din,
    output logic [NCLIENT-1:0]     cl_strobe,
    output logic [NCLIENT-1:0]     cl_active,
    output logic [NCLIENT-1:0]     cl_abort,
    input  logic [16*NCLIENT-1:0]  cl_dout,
    output logic [7:0]             unclaimed_cnt
);

    arb_state_e         state_q, state_d;
    logic [15:0]        bus_din_q;
    logic               bus_stb_q, bus_en_q;
    logic [NCLIENT-1:0] sel_q, sel_d, strobe_q, strobe_d, active_q, active_d, abort_q, abort_d;
    logic [7:0]         cmd_q, cmd_d, uncl_q, uncl_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        din_q, din_d, dout_q, dout_d, reply_s;
    logic               dout_en_q, dout_en_d;
    logic [NCLIENT-1:0] dec_sel_s;
    logic               dec_hit_s;

    ext_cmd_decode #(
        .NCLIENT (NCLIENT),
        .CMD_LO  (CMD_LO),
        .CMD_HI  (CMD_HI)
    ) u_decode (
        .cmd (bus_din_q[7:0]),
        .sel (dec_sel_s),
        .hit (dec_hit_s)
    );

    // Reply word of the selected client.
    always_comb begin
        reply_s = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            if (sel_q[i]) begin
                reply_s = reply_s | cl_dout[16*i +: 16];
            end else begin
                reply_s = reply_s;
            end
        end
    end

    // Next-state and output logic; a low enable overrides every other event.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        strobe_d  = '0;
        active_d  = active_q;
        abort_d   = '0;
        dout_d    = '0;
        dout_en_d = dout_en_q;
        uncl_d    = uncl_q;
        if (!bus_en_q) begin
            state_d   = ST_IDLE;
            active_d  = '0;
            dout_en_d = 1'b0;
            cnt_d     = 4'd0;
            if (state_q == ST_ROUTE) begin
                abort_d = sel_q;
            end else begin
                abort_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = 4'd0;
                end
                ST_CMD: begin
                    if (bus_stb_q) begin
                        cmd_d = bus_din_q[7:0];
                        din_d = bus_din_q;
                        cnt_d = 4'd0;
                        if (dec_hit_s) begin
                            state_d   = ST_ROUTE;
                            sel_d     = dec_sel_s;
                            active_d  = dec_sel_s;
                            strobe_d  = dec_sel_s;
                            dout_en_d = 1'b1;
                        end else begin
                            state_d   = ST_DROP;
                            dout_en_d = 1'b0;
                            uncl_d    = sat_inc8(uncl_q);
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ROUTE: begin
                    dout_d = reply_s;
                    if (bus_stb_q) begin
                        cnt_d    = sat_inc4(cnt_q);
                        din_d    = bus_din_q;
                        strobe_d = sel_q;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DROP: begin
                    state_d = ST_DROP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Bus inputs are registered once, so every response lands one edge later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus_din_q <= 16'd0;
            bus_stb_q <= 1'b0;
            bus_en_q  <= 1'b0;
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cmd_q     <= 8'd0;
            cnt_q     <= 4'd0;
            din_q     <= 16'd0;
            strobe_q  <= '0;
            active_q  <= '0;
            abort_q   <= '0;
            dout_q    <= 16'd0;
            dout_en_q <= 1'b0;
            uncl_q    <= 8'd0;
        end else begin
            bus_din_q <= EXT_BUS[BUS_DIN_LSB +: 16];
            bus_stb_q <= EXT_BUS[BUS_STROBE];
            bus_en_q  <= EXT_BUS[BUS_ENABLE];
            state_q   <= state_d;
            sel_q     <= sel_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
            abort_q   <= abort_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            uncl_q    <= uncl_d;
        end
    end

    assign EXT_BUS[BUS_DOUT_LSB +: 16] = dout_q;
    assign EXT_BUS[BUS_DOUT_EN]        = dout_en_q;

    assign cl_cmd        = cmd_q;
    assign cl_cnt        = cnt_q;
    assign cl_din        = din_q;
    assign cl_strobe     = strobe_q;
    assign cl_active     = active_q;
    assign cl_abort      = abort_q;
    assign unclaimed_cnt = uncl_q;

endmodule
